// File: rtl/tx_fifo_pkg.sv
// Shared constants and status-vector layout for the transmit-path FIFO.
// The status struct field order is also consumed by the flow-control arbiter.
package tx_fifo_pkg;

   localparam int DEF_DATA_W = 6;
   localparam int DEF_ADDR_W = 2;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } tx_status_t;

   localparam tx_status_t STATUS_RESET = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                                          almost_empty: 1'b0, overflow: 1'b0, underflow: 1'b0};

endpackage

// File: rtl/tx_fifo_mem.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read, clear on reset or init=0.
module tx_fifo_mem
   import tx_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              init,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (!init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tx_fifo_param.sv
// Parametrised transmit FIFO with thresholds, sticky error flags and a registered read port.
// Optional macro TX_FIFO_OUT_HOLD_EN: data_out holds the last popped word instead of returning to 0.
module tx_fifo_param
   import tx_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              init,
   input  logic              wr_enable,
   input  logic              rd_enable,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W:0]   umbral_af,
   input  logic [ADDR_W:0]   umbral_ae,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [ADDR_W:0]   fill_count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   // Margins above DEPTH would wrap the full-threshold subtraction, so clamp them.
   function automatic logic [ADDR_W:0] sat_margin(input logic [ADDR_W:0] m);
      return (m > DEPTH_C) ? DEPTH_C : m;
   endfunction

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count;
   logic              ovf_q, unf_q;
   logic              push_ok, pop_ok;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] dout_p1;
   logic              vld_p1;
   logic [ADDR_W:0]   af_margin;
   tx_status_t        st;

   // A push into a full FIFO is only legal when a pop frees a slot at the same edge.
   assign pop_ok  = rd_enable && (count != '0);
   assign push_ok = wr_enable && ((count != DEPTH_C) || pop_ok);

   tx_fifo_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .reset_L (reset_L),
      .init    (init),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   // Stage p0 -> p1: pointer/count/error update and registered read port
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         vld_p1  <= 1'b0;
         dout_p1 <= '0;
      end else if (!init) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         vld_p1  <= 1'b0;
         dout_p1 <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
         if (wr_enable && !push_ok) ovf_q <= 1'b1;
         if (rd_enable && !pop_ok)  unf_q <= 1'b1;
         vld_p1 <= pop_ok;
`ifdef TX_FIFO_OUT_HOLD_EN
         if (pop_ok) dout_p1 <= rd_data;
`else
         dout_p1 <= pop_ok ? rd_data : '0;
`endif
      end
   end

   always_comb begin
      af_margin = sat_margin(umbral_af);
      st        = STATUS_RESET;
      if (reset_L && init) begin
         st.full         = (count == DEPTH_C);
         st.empty        = (count == '0);
         st.almost_full  = (af_margin != '0) && (count >= (DEPTH_C - af_margin)) && (count != DEPTH_C);
         st.almost_empty = (umbral_ae != '0) && (count <= umbral_ae) && (count != '0);
         st.overflow     = ovf_q;
         st.underflow    = unf_q;
      end
   end

   assign fill_count   = (reset_L && init) ? count : '0;
   assign full         = st.full;
   assign empty        = st.empty;
   assign almost_full  = st.almost_full;
   assign almost_empty = st.almost_empty;
   assign overflow     = st.overflow;
   assign underflow    = st.underflow;
   assign data_out     = dout_p1;
   assign data_valid   = vld_p1;

endmodule

// File: tb/tb_tx_fifo_param.sv
// Directed bench for tx_fifo_param: queue-based reference model checked every cycle plus literal pins.
module tb_tx_fifo_param;

   logic       clk = 1'b0;
   logic       reset_L, init, wr_enable, rd_enable;
   logic [5:0] data_in;
   logic [2:0] umbral_af, umbral_ae;
   logic [5:0] data_out;
   logic       data_valid;
   logic [2:0] fill_count;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;

   int n_cmp = 0;
   int n_bad = 0;

   tx_fifo_param #(.DATA_W(6), .ADDR_W(2)) dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .init         (init),
      .wr_enable    (wr_enable),
      .rd_enable    (rd_enable),
      .data_in      (data_in),
      .umbral_af    (umbral_af),
      .umbral_ae    (umbral_ae),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .fill_count   (fill_count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of words plus sticky flags
   logic [5:0] q[$];
   bit         m_ovf, m_unf, m_vld;
   logic [5:0] m_dout;
   bit         m_pop, m_push;

   always @(posedge clk or negedge reset_L) begin
      if (!reset_L || !init) begin
         q.delete();
         m_ovf  = 0;
         m_unf  = 0;
         m_vld  = 0;
         m_dout = '0;
      end else begin
         m_pop  = rd_enable && (q.size() > 0);
         m_push = wr_enable && ((q.size() < 4) || m_pop);
         if (m_pop) begin
            m_dout = q.pop_front();
            m_vld  = 1;
         end else begin
            m_vld = 0;
`ifndef TX_FIFO_OUT_HOLD_EN
            m_dout = '0;
`endif
         end
         if (m_push) q.push_back(data_in);
         if (wr_enable && !m_push) m_ovf = 1;
         if (rd_enable && !m_pop)  m_unf = 1;
      end
   end

   always @(posedge clk) begin
      int n, a;
      bit run;
      #2;
      run = reset_L && init;
      n   = run ? q.size() : 0;
      a   = (umbral_af > 3'd4) ? 4 : int'(umbral_af);
      chk("m_fill_count",   fill_count,   n);
      chk("m_full",         full,         run && n == 4);
      chk("m_empty",        empty,        !run || n == 0);
      chk("m_almost_full",  almost_full,  run && a != 0 && n >= 4 - a && n != 4);
      chk("m_almost_empty", almost_empty, run && umbral_ae != 0 && n <= int'(umbral_ae) && n != 0);
      chk("m_overflow",     overflow,     run && m_ovf);
      chk("m_underflow",    underflow,    run && m_unf);
      chk("m_data_valid",   data_valid,   m_vld);
      chk("m_data_out",     data_out,     m_dout);
   end

   task automatic step(input bit w, input bit r, input logic [5:0] d);
      @(negedge clk);
      wr_enable = w;
      rd_enable = r;
      data_in   = d;
      @(posedge clk);
      #3;
   endtask

   initial begin
      logic [5:0] exp_words [4];
      exp_words[0] = 6'h15; exp_words[1] = 6'h2A; exp_words[2] = 6'h03; exp_words[3] = 6'h3F;
      reset_L = 0; init = 1; wr_enable = 0; rd_enable = 0; data_in = '0;
      umbral_af = 3'd1; umbral_ae = 3'd1;
      #1;
      chk("rst_empty", empty, 1);
      chk("rst_fill", fill_count, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_flags", {full, almost_full, almost_empty, overflow, underflow, data_valid}, 0);
      repeat (2) @(negedge clk);
      reset_L = 1;

      step(1, 0, 6'h15); step(1, 0, 6'h2A); step(1, 0, 6'h03);
      chk("fill3_af", almost_full, 1);
      chk("fill3_count", fill_count, 3);
      step(1, 0, 6'h3F);
      chk("fill4_full", full, 1);
      chk("fill4_af", almost_full, 0);
      chk("fill4_count", fill_count, 4);
      step(1, 0, 6'h01);
      chk("ovf_set", overflow, 1);
      chk("ovf_fill", fill_count, 4);
      step(0, 0, 6'h00);
      chk("ovf_sticky", overflow, 1);

      for (int i = 0; i < 4; i++) begin
         step(0, 1, 6'h00);
         chk("drain_dout", data_out, exp_words[i]);
         chk("drain_vld", data_valid, 1);
         if (i == 2) chk("fill1_ae", almost_empty, 1);
      end
      chk("drain_empty", empty, 1);
      step(0, 1, 6'h00);
      chk("unf_vld", data_valid, 0);
      chk("unf_set", underflow, 1);

      step(1, 0, 6'h0A); step(1, 0, 6'h0B);
      chk("pre_clr_fill", fill_count, 2);
      chk("pre_clr_ovf", overflow, 1);
      @(negedge clk);
      init = 0; wr_enable = 1; data_in = 6'h0C;
      @(posedge clk); #3;
      chk("clr_fill", fill_count, 0);
      chk("clr_empty", empty, 1);
      chk("clr_ovf", overflow, 0);
      @(negedge clk);
      init = 1; wr_enable = 0;
      @(posedge clk); #3;
      chk("post_clr_fill", fill_count, 0);
      chk("post_clr_vld", data_valid, 0);
      chk("post_clr_flags", {overflow, underflow}, 0);

      umbral_af = 3'd0;
      step(1, 0, 6'h01);
      chk("ae_fill1", almost_empty, 1);
      step(1, 0, 6'h02); step(1, 0, 6'h03);
      chk("af0_fill3", almost_full, 0);
      step(1, 0, 6'h04);
      chk("af0_full", full, 1);

      for (int i = 0; i < 8; i++) step(1, 1, 6'h20 + 6'(i));
      chk("sim_fill", fill_count, 4);
      chk("sim_ovf", overflow, 0);
      chk("sim_last_dout", data_out, 6'h23);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 6'h00);
         chk("wrap_dout", data_out, 6'h24 + 6'(i));
      end

      step(1, 1, 6'h11);
      chk("pp_empty_fill", fill_count, 1);
      chk("pp_empty_unf", underflow, 1);
      chk("pp_empty_vld", data_valid, 0);

      @(negedge clk);
      wr_enable = 0; rd_enable = 0;
      umbral_af = 3'd7;
      #1 chk("af_sat", almost_full, 1);
      umbral_ae = 3'd0;
      #1 chk("ae_zero", almost_empty, 0);
      umbral_af = 3'd1; umbral_ae = 3'd1;

      step(1, 0, 6'h12);
      chk("pre_rst_fill", fill_count, 2);
      @(negedge clk);
      wr_enable = 1; data_in = 6'h13;
      #3 reset_L = 0;
      #1;
      chk("arst_fill", fill_count, 0);
      chk("arst_empty", empty, 1);
      chk("arst_dout", data_out, 0);
      chk("arst_flags", {full, almost_full, almost_empty, overflow, underflow, data_valid}, 0);
      @(negedge clk);
      reset_L = 1;
      @(posedge clk); #3;
      chk("post_rst_push", fill_count, 1);
      step(0, 0, 6'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tx_fifo_param.md
# tx_fifo_param

Parametrised transmit-path FIFO with programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, a registered read port with valid strobe and fill-level reporting. It buffers symbols between the transaction-layer producer and the lane-side consumer in the PCIe transmit layer. It replaces the fixed per-stage D-FIFOs with one generic block: width, depth and thresholds set per instance, and illegal accesses flagged instead of silently corrupting the count.

## Interface
- DATA_W, 6, word width in bits
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W
- clk  in  1  rising-edge clock, only clock
- reset_L  in  1  reset, asynchronous, active-low
- init  in  1  synchronous soft clear when 0, run when 1
- wr_enable  in  1  push request
- rd_enable  in  1  pop request
- data_in  in  DATA_W  push data
- umbral_af  in  ADDR_W+1  almost-full margin
- umbral_ae  in  ADDR_W+1  almost-empty level
- data_out  out  DATA_W  popped word, registered
- data_valid  out  1  data_out carries a popped word this cycle
- fill_count  out  ADDR_W+1  stored words, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1 each  status
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Storage: DEPTH x DATA_W. Pointers wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH. Count is ADDR_W+1 bits and never leaves 0..DEPTH.
- Push is accepted when wr_enable=1 and (fill<DEPTH, or rd_enable=1 with fill>0). A rejected push drops the data, leaves ptr and count unchanged, and sets overflow.
- Pop is accepted when rd_enable=1 and fill>0. A pop on empty is ignored and sets underflow. There is no write-to-read bypass: simultaneous push+pop at fill=0 accepts the push, ignores the pop and sets underflow.
- Count update: push only +1; pop only -1; both accepted: unchanged.
- Status is combinational from count:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (umbral_af!=0) && (count >= DEPTH-umbral_af) && !full
  - almost_empty = (umbral_ae!=0) && (count <= umbral_ae) && !empty
  - Comparisons are unsigned at ADDR_W+1 bits. umbral_af>DEPTH saturates to DEPTH.
- overflow and underflow stay set until reset_L=0 or init=0.
- init=0 at a clock edge clears pointers, count, memory, errors and data_out/data_valid. While init=0, status is forced to reset values and all requests are ignored.

## Timing
- Reset (async, reset_L=0): data_out=0, data_valid=0, fill_count=0, full=0, empty=1, almost_full=0, almost_empty=0, overflow=0, underflow=0. Pointers and memory are 0.
- Write latency: the word is stored at the edge with wr_enable=1. Count and status update at the same edge, so they are visible the following cycle.
- Read latency: 1 cycle. Pop at edge N puts data_out and data_valid=1 valid after edge N.
- Error flags rise at the edge that sees the illegal request.
- Reset asserted mid-stream clears all state immediately, without waiting for clk. The first accepted request comes at the first edge after reset_L=1 with init=1.
- Threshold input changes affect status in the same cycle (combinational).

## Configuration
- TX_FIFO_OUT_HOLD_EN
  - Defined: data_out holds the last popped word on cycles without an accepted pop; data_valid still drops to 0.
  - Undefined: data_out returns to 0 on every cycle without an accepted pop.

## Structure
- Shared package tx_fifo_pkg holds:
  - default DATA_W/ADDR_W constants
  - the status-vector field order {full, empty, almost_full, almost_empty, overflow, underflow}, reused by the flow-control arbiter
- One sub-module, tx_fifo_mem: DEPTH x DATA_W register file with a synchronous write port, async read address and init clear.
- Pointer, count, status and error logic stay in the top module.

## Test plan
All scenarios use DATA_W=6, ADDR_W=2.
- Reset: hold reset_L=0 mid-traffic -> immediately empty=1, fill_count=0, data_out=0, all other flags 0.
- Overflow: push 6'h15, 6'h2A, 6'h03, 6'h3F -> full=1, fill_count=4. Then push 6'h01 -> dropped, overflow=1 and stays 1; later pops return only the four original words.
- Drain and underflow: pop x4 -> data_out = 15, 2A, 03, 3F, each one cycle after its rd_enable, with data_valid=1; then empty=1. A fifth pop gives data_valid=0 and underflow=1.
- Thresholds: with umbral_af=1 and umbral_ae=1:
  - fill 3 -> almost_full=1.
  - fill 4 -> almost_full=0, full=1.
  - fill 1 -> almost_empty=1.
  - umbral_af=0 -> almost_full never asserts.
- Simultaneous access at full: push+pop with fill=4 -> fill stays 4, no overflow, pointers wrap 3->0 correctly over 8 cycles.
- Soft clear: init=0 for one edge with fill=2 and overflow=1 -> fill_count=0, empty=1, overflow=0, data_valid=0.
